// File: rtl/bcd_pkg.sv
// Shared state encoding and digit constants for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} conv_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;
    localparam logic [3:0] BCD_MAX        = 4'd9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD digit after the right shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit_c
);

    // A digit >= 8 after shifting right holds a borrowed half-ten; 8-3 >= 5, so no wrap.
    assign o_digit_c = (i_digit >= BCD_ADJ_THRESH) ? (i_digit - BCD_ADJ_SUB) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one right shift plus per-digit correction per clock,
// BIN_W iterations per number, result returned over a valid/ready handshake.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    conv_state_t       r_state;
    conv_state_t       w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              w_in_ready_nxt;
    logic              w_out_valid_nxt;

    logic [SR_W-1:0]   r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err_lat;
    logic [BIN_W-1:0]  r_bin_out;
    logic              r_err;

    logic              w_accept;
    logic              w_last;
    logic              w_digit_err;
    logic [SR_W-1:0]   w_shifted;
    logic [BCD_W-1:0]  w_bcd_adj;
    logic [SR_W-1:0]   w_shift_adj;

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_state == S_CONV) && (r_cnt == LAST_CNT);

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)              w_state_nxt = S_CONV;
            S_CONV:  if (r_cnt == LAST_CNT)     w_state_nxt = S_DONE;
            S_DONE:  if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode and invalid-digit detection.
    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_digit_err     = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > BCD_MAX) w_digit_err = 1'b1;
        end
    end

    assign w_shifted = r_shift >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit   (w_shifted[BIN_W + 4*g +: 4]),
            .o_digit_c (w_bcd_adj[4*g +: 4])
        );
    end

    assign w_shift_adj = {w_bcd_adj, w_shifted[BIN_W-1:0]};

    // Shift register, iteration counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_err_lat <= 1'b0;
            r_bin_out <= '0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_accept) begin
                r_shift   <= {bcd_in, {BIN_W{1'b0}}};
                r_cnt     <= '0;
                r_err_lat <= w_digit_err;
            end else if (r_state == S_CONV) begin
                r_shift <= w_shift_adj;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            // Results only change on entry to DONE so they hold through IDLE/CONV.
            if (w_last) begin
                r_err     <= r_err_lat;
                r_bin_out <= r_err_lat ? '0 : w_shift_adj[BIN_W-1:0];
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bin_out   = r_bin_out;
    assign err       = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed and randomised scoreboard bench for bcd_to_bin_seq.
module tb_bcd_to_bin_seq;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned BIN_W  = 14;
    localparam int unsigned LAT    = BIN_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       bcd_in;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    int errors = 0;
    int checks = 0;
    logic [BIN_W:0] sb_q [$];

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: weighted decimal sum of the digits, flagged if any digit exceeds 9.
    function automatic logic [BIN_W:0] model(input logic [15:0] bcd);
        int unsigned v;
        int unsigned w;
        logic        e;
        logic [3:0]  d;
        v = 0; w = 1; e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) e = 1'b1;
            v = v + w * int'(d);
            w = w * 10;
        end
        return e ? {1'b1, BIN_W'(0)} : {1'b0, BIN_W'(v)};
    endfunction

    task automatic convert(input logic [15:0] bcd, input logic [BIN_W:0] exp,
                           input int hold, input bit poke, input string tag);
        int k;
        logic [BIN_W:0] e;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        bcd_in    = bcd;
        sb_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        bcd_in   = '0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 100) begin
            if (poke) begin
                in_valid = 1'b1;
                bcd_in   = 16'h0555;
            end
            @(negedge clk);
            k++;
            if (poke) check({tag, "_conv_rdy"}, 32'(in_ready), 32'd0);
        end
        check({tag, "_latency"}, 32'(k), 32'(LAT));
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        check({tag, "_bin"}, 32'(bin_out), 32'(e[BIN_W-1:0]));
        check({tag, "_err"}, 32'(err), 32'(e[BIN_W]));
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                in_valid = 1'b1;
                bcd_in   = 16'h0555;
            end
            @(negedge clk);
            check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_bin"}, 32'(bin_out), 32'(e[BIN_W-1:0]));
            if (poke) check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        bcd_in    = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        bcd_in    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(16'h1234, {1'b0, 14'd1234}, 0, 1'b0, "d1234");
        convert(16'h0000, {1'b0, 14'd0},    0, 1'b0, "d0000");
        convert(16'h9999, {1'b0, 14'd9999}, 0, 1'b0, "d9999");
        convert(16'h0010, {1'b0, 14'd10},   0, 1'b0, "d0010");
        convert(16'h12A4, {1'b1, 14'd0},    0, 1'b0, "bad_digit");

        // Abort a conversion mid-flight with an asynchronous reset.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bcd_in    = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        bcd_in   = '0;
        repeat (6) @(negedge clk);
        check("mid_busy", 32'(in_ready), 32'd0);
        check("mid_err_held", 32'(err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_bin_out", 32'(bin_out), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert(16'h0042, {1'b0, 14'd42}, 0, 1'b0, "after_rst");

        convert(16'h0987, {1'b0, 14'd987}, 20, 1'b1, "backpressure");
        convert(16'h0005, {1'b0, 14'd5},   0,  1'b0, "after_bp");

        for (int n = 0; n < 500; n++) begin
            for (int d = 0; d < DIGITS; d++) rb[4*d +: 4] = 4'($urandom_range(0, 9));
            convert(rb, model(rb), int'($urandom_range(0, 3)), 1'b0, "rnd");
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
